// File: rtl/me_stage_unit.sv
// Memory-access stage: issues loads/stores on the SRAM-like data bus, aligns load data, hands results to WB.
// Optional ME_LOAD_BYPASS_EN: load response forwarded to WB in the data_ok cycle when WB can take it.
module me_stage_unit (
  input  logic         clk,
  input  logic         resetn,
  input  logic         EX_to_ME_Valid,
  input  logic [106:0] EX_to_ME_Bus,
  output logic         ME_Allow_in,
  output logic         data_req,
  output logic         data_wr,
  output logic [1:0]   data_size,
  output logic [3:0]   data_wstrb,
  output logic [31:0]  data_addr,
  output logic [31:0]  data_wdata,
  input  logic         data_addr_ok,
  input  logic         data_data_ok,
  input  logic [31:0]  data_rdata,
  input  logic         WB_Allow_in,
  output logic         ME_to_WB_Valid,
  output logic [69:0]  ME_to_WB_Bus,
  output logic [4:0]   ME_dest,
  output logic [31:0]  ME_Forward_Res,
  output logic         ME_Fwd_Ready
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic [31:0] load_align(input logic [2:0] op, input logic [1:0] lo,
                                             input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rd[{lo, 3'b000} +: 8];
    h = lo[1] ? rd[31:16] : rd[15:0];
    case (op)
      3'd0:    r = {{24{b[7]}}, b};
      3'd1:    r = {{16{h[15]}}, h};
      3'd3:    r = {24'd0, b};
      3'd4:    r = {16'd0, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] op_size(input logic [2:0] op);
    logic [1:0] s;
    case (op)
      3'd0, 3'd3, 3'd5: s = 2'd0;
      3'd1, 3'd4, 3'd6: s = 2'd1;
      default:          s = 2'd2;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] op, input logic [1:0] lo);
    logic [3:0] s;
    case (op)
      3'd5:    s = 4'b0001 << lo;
      3'd6:    s = 4'b0011 << {lo[1], 1'b0};
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] op, input logic [31:0] st);
    logic [31:0] d;
    case (op)
      3'd5:    d = {4{st[7:0]}};
      3'd6:    d = {2{st[15:0]}};
      default: d = st;
    endcase
    return d;
  endfunction

  state_t      state_r, state_nxt_s;
  logic [31:0] pc_r;
  logic        gr_we_r;
  logic [4:0]  dest_r;
  logic        mem_we_r;
  logic [2:0]  mem_op_r;
  logic [31:0] st_data_r;
  logic [31:0] alu_r;
  logic [31:0] result_r;

  logic        bypass_fire_s;
  logic        allow_in_s;
  logic        accept_s;
  logic [31:0] aligned_s;
  logic [31:0] final_s;

  assign aligned_s = load_align(mem_op_r, alu_r[1:0], data_rdata);

`ifdef ME_LOAD_BYPASS_EN
  assign bypass_fire_s = (state_r == ST_RESP) && data_data_ok && WB_Allow_in && !mem_we_r;
`else
  assign bypass_fire_s = 1'b0;
`endif

  assign allow_in_s = (state_r == ST_IDLE) || ((state_r == ST_DONE) && WB_Allow_in) || bypass_fire_s;
  assign accept_s   = EX_to_ME_Valid && allow_in_s;
  assign final_s    = bypass_fire_s ? aligned_s : result_r;

  // Next-state decode; a same-cycle accept always wins over the drain/idle transitions.
  always_comb begin
    state_nxt_s = state_r;
    if (accept_s) begin
      state_nxt_s = EX_to_ME_Bus[68] ? ST_REQ : ST_DONE;
    end else begin
      case (state_r)
        ST_IDLE: state_nxt_s = ST_IDLE;
        ST_REQ:  state_nxt_s = data_addr_ok ? ST_RESP : ST_REQ;
        ST_RESP: begin
          if (data_data_ok) begin
            state_nxt_s = bypass_fire_s ? ST_IDLE : ST_DONE;
          end else begin
            state_nxt_s = ST_RESP;
          end
        end
        ST_DONE: state_nxt_s = WB_Allow_in ? ST_IDLE : ST_DONE;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Instruction fields latched on accept; load result overwrites alu_result when data returns.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_r      <= 32'd0;
      gr_we_r   <= 1'b0;
      dest_r    <= 5'd0;
      mem_we_r  <= 1'b0;
      mem_op_r  <= 3'd0;
      st_data_r <= 32'd0;
      alu_r     <= 32'd0;
      result_r  <= 32'd0;
    end else if (accept_s) begin
      pc_r      <= EX_to_ME_Bus[106:75];
      gr_we_r   <= EX_to_ME_Bus[74];
      dest_r    <= EX_to_ME_Bus[73:69];
      mem_we_r  <= EX_to_ME_Bus[67];
      mem_op_r  <= EX_to_ME_Bus[66:64];
      st_data_r <= EX_to_ME_Bus[63:32];
      alu_r     <= EX_to_ME_Bus[31:0];
      result_r  <= EX_to_ME_Bus[31:0];
    end else if ((state_r == ST_RESP) && data_data_ok && !mem_we_r) begin
      result_r  <= aligned_s;
    end
  end

  assign ME_Allow_in    = allow_in_s;
  assign data_req       = (state_r == ST_REQ);
  assign data_wr        = mem_we_r;
  assign data_size      = op_size(mem_op_r);
  assign data_wstrb     = mem_we_r ? store_strb(mem_op_r, alu_r[1:0]) : 4'b0000;
  assign data_addr      = alu_r;
  assign data_wdata     = store_data(mem_op_r, st_data_r);
  assign ME_to_WB_Valid = (state_r == ST_DONE) || bypass_fire_s;
  assign ME_to_WB_Bus   = {pc_r, gr_we_r, dest_r, final_s};
  assign ME_dest        = ((state_r != ST_IDLE) && gr_we_r) ? dest_r : 5'd0;
  assign ME_Forward_Res = result_r;
  assign ME_Fwd_Ready   = (state_r == ST_DONE);

endmodule

// File: doc/me_stage_unit.md
# me_stage_unit

Memory-access pipeline stage of the 5-stage LoongArch core, sitting between the execute stage and WB_Unit. Accepts one instruction at a time from EX, issues its load/store on the SRAM-like data bus (request/address-ok/data-ok), aligns and extends load data, and drives the 70-bit ME-to-WB bus with a valid/allow-in handshake. Also exports destination and result for forwarding and load-use interlock.

## Interface
- No parameters.
- clk  in  1  core clock; all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- EX_to_ME_Valid  in  1  EX presents an instruction
- EX_to_ME_Bus  in  107  {pc[106:75], gr_we[74], dest[73:69], mem_en[68], mem_we[67], mem_op[66:64], st_data[63:32], alu_result[31:0]}
- ME_Allow_in  out  1  stage can accept this cycle
- data_req  out  1  data-bus request
- data_wr  out  1  1 = store
- data_size  out  2  0 byte, 1 half, 2 word
- data_wstrb  out  4  byte enables (stores)
- data_addr  out  32  byte address = alu_result
- data_wdata  out  32  store data, lane-replicated
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  response (load data / store ack)
- data_rdata  in  32  load data
- WB_Allow_in  in  1  WB can accept
- ME_to_WB_Valid  out  1  bus valid
- ME_to_WB_Bus  out  70  {pc[69:38], gr_we[37], dest[36:32], final_result[31:0]}
- ME_dest  out  5  dest if valid and gr_we, else 0
- ME_Forward_Res  out  32  final_result
- ME_Fwd_Ready  out  1  1 when final_result is valid for forwarding (state DONE)

## Operation
- mem_op: 0 ld.b, 1 ld.h, 2 ld.w, 3 ld.bu, 4 ld.hu, 5 st.b, 6 st.h, 7 st.w. mem_we=1 only for 5–7.
- States: IDLE (empty), REQ (data_req=1, await addr_ok), RESP (await data_ok), DONE (result held, ME_to_WB_Valid=1).
- ME_Allow_in = IDLE || (DONE && WB_Allow_in).
- Accept (EX_to_ME_Valid && ME_Allow_in): latch bus; mem_en → REQ, else DONE with final_result=alu_result.
- REQ: data_addr_ok → RESP. RESP: data_data_ok → DONE; loads capture aligned data, stores keep final_result=alu_result.
- DONE && WB_Allow_in: transfer; next state per simultaneous accept, else IDLE.
- Load extract by addr[1:0]: byte lane addr[1:0], half lane addr[1]; ld.b/ld.h sign-extend, bu/hu zero-extend.
- Store: wstrb byte = 1<<addr[1:0]; half = 4'b0011<<{addr[1],1'b0}; word = 4'b1111. wdata = {4{b}}, {2{h}}, or word.
- data_data_ok outside RESP ignored. Alignment faults not detected.

## Timing
- Reset: state IDLE, ME_Allow_in=1, data_req=0, ME_to_WB_Valid=0, ME_dest=0, ME_Fwd_Ready=0, latched fields 0.
- Non-memory: accepted cycle N, ME_to_WB_Valid at N+1.
- Memory: data_req from N+1; addr_ok cycle A; data_ok earliest A+1 (D); DONE at D+1.
- data_req, data_addr, data_size, data_wstrb, data_wdata stable while in REQ.
- Back-to-back: DONE with WB_Allow_in and a new EX instruction transfers and accepts same cycle; no bubble.
- WB_Allow_in=0 in DONE: bus held unchanged, ME_Allow_in=0.
- resetn low mid-transaction: immediately IDLE, data_req=0; a pending response is dropped.

## Configuration
- ME_LOAD_BYPASS_EN defined: in RESP, data_data_ok with WB_Allow_in=1 drives ME_to_WB_Valid=1 and final_result from aligned data_rdata that cycle (combinational); transfer completes, next state IDLE or new accept. If WB_Allow_in=0, data captured, go DONE. ME_Fwd_Ready stays DONE-only.
- Undefined: always via DONE (latency as in Timing).

## Test plan
- Non-memory add, alu_result=0x12345678, dest=5, WB_Allow_in=1 → next cycle ME_to_WB_Bus final_result=0x12345678, dest=5, ME_dest=5.
- ld.b addr 0x1003, rdata 0x80FF_0000 → final_result 0xFFFF_FF80; ld.bu same → 0x0000_0080; ld.hu addr 0x1002 → 0x0000_80FF.
- st.h addr 0x2002, st_data 0xAAAA_BEEF → data_wr=1, size=1, wstrb=4'b1100, wdata=0xBEEF_BEEF; held until addr_ok.
- Load in DONE, WB_Allow_in=0 for 3 cycles → bus and ME_Allow_in=0 held; drop, then new EX instruction accepted same cycle.
- resetn low while in RESP, data_data_ok next cycle → IDLE, ME_to_WB_Valid stays 0.
- With ME_LOAD_BYPASS_EN: ld.w, data_ok with WB_Allow_in=1 → ME_to_WB_Valid and rdata same cycle; without: one cycle later.
